// File: rtl/if_pkg.sv
// Shared definitions for the prefetching instruction fetch stage.
// Holds the default datapath width and reset PC, plus the redirect
// source encoding and its priority resolver.
package if_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // Redirect source, ordered so that the encoding also reads as priority.
  typedef enum logic [1:0] {
    RedirNone   = 2'd0,
    RedirBranch = 2'd1,
    RedirJump   = 2'd2,
    RedirJReg   = 2'd3
  } redir_e;

  // JR/JALR wins over J/JAL, which wins over a taken branch.
  function automatic redir_e redir_sel(input logic jreg, input logic jump, input logic branch);
    if (jreg) begin
      return RedirJReg;
    end else if (jump) begin
      return RedirJump;
    end else if (branch) begin
      return RedirBranch;
    end
    return RedirNone;
  endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// Prefetch queue: DEPTH entries of WIDTH bits with push, pop and flush.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   push       - write push_data at the tail
//   push_data  - entry to enqueue
//   pop        - drop the head entry
//   flush      - empty the queue (wins over push/pop)
//   head       - head entry, read straight from the storage registers
//   count      - current occupancy (0..DEPTH)
//   empty      - occupancy is zero
module if_prefetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/if_stage_prefetch.sv
// Instruction fetch stage with a prefetch queue in front of decode.
// Issues word fetches over a req/gnt/valid interface (in-order, variable
// latency), buffers returned instructions with their PC+4, and discards
// responses that belong to a stream abandoned by a redirect.
// Ports:
//   Clk, Reset                    - clock, asynchronous active-high reset
//   Stall                         - decode holds the head entry
//   Branch_E, Jump_E, JReg        - redirect requests (JReg > Jump_E > Branch_E)
//   BranchAddr, Jaddr, JRegAddr   - redirect targets
//   MemReq, MemAddr, MemGnt       - fetch request channel (word address)
//   MemValid, MemData             - in-order response channel
//   Inst_I, PCplus4_I, InstValid_I - queue head presented to decode
module if_stage_prefetch
  import if_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter int unsigned     IMEM_AW  = 12,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Stall,
  input  logic               Branch_E,
  input  logic               Jump_E,
  input  logic               JReg,
  input  logic [XLEN-1:0]    BranchAddr,
  input  logic [XLEN-1:0]    Jaddr,
  input  logic [XLEN-1:0]    JRegAddr,
  output logic               MemReq,
  output logic [IMEM_AW-1:0] MemAddr,
  input  logic               MemGnt,
  input  logic               MemValid,
  input  logic [XLEN-1:0]    MemData,
  output logic [XLEN-1:0]    Inst_I,
  output logic [XLEN-1:0]    PCplus4_I,
  output logic               InstValid_I
);

  localparam int unsigned OW = $clog2(MAX_OUT + 1);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned QW = 2 * XLEN;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [OW-1:0]   out_q, out_d;
  logic [OW-1:0]   drop_q, drop_d;

  redir_e          redir;
  logic            redirect;
  logic [XLEN-1:0] target;
  logic [CW-1:0]   occ;
  logic            empty;
  logic [QW-1:0]   head;
  logic            rsp_valid, grant, do_push, do_pop;

  // Redirect mux; targets are word aligned regardless of the low bits.
  always_comb begin
    redir  = redir_sel(JReg, Jump_E, Branch_E);
    target = '0;
    unique case (redir)
      RedirJReg:   target = JRegAddr;
      RedirJump:   target = Jaddr;
      RedirBranch: target = BranchAddr;
      default:     target = '0;
    endcase
    target[1:0] = 2'b00;
  end

  assign redirect = (redir != RedirNone);

  // A response with nothing outstanding is a leftover from before reset.
  assign rsp_valid = MemValid && (out_q != '0);

  // Credits: queued plus in-flight never exceeds DEPTH, so pushes always fit.
  assign MemReq  = !Reset && !redirect && (32'(out_q) < MAX_OUT)
                   && ((32'(occ) + 32'(out_q)) < DEPTH);
  assign MemAddr = fetch_pc_q[IMEM_AW+1:2];
  assign grant   = MemReq && MemGnt;
  assign do_push = rsp_valid && !redirect && (drop_q == '0);
  assign do_pop  = !empty && !Stall && !redirect;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_d      = out_q;
    drop_d     = drop_q;
    if (redirect) begin
      fetch_pc_d = target;
      resp_pc_d  = target;
      out_d      = out_q - OW'(rsp_valid);
      // Everything still in flight belongs to the abandoned stream.
      drop_d     = out_q - OW'(rsp_valid);
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      out_d = out_q + OW'(grant) - OW'(rsp_valid);
      if (rsp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - OW'(1);
        end else begin
          resp_pc_d = resp_pc_q + XLEN'(4);
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  if_prefetch_fifo #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (Clk),
    .rst       (Reset),
    .push      (do_push),
    .push_data ({MemData, resp_pc_q + XLEN'(4)}),
    .pop       (do_pop),
    .flush     (redirect),
    .head      (head),
    .count     (occ),
    .empty     (empty)
  );

  // Stale storage stays hidden behind the empty flag.
  assign InstValid_I = !empty;
  assign Inst_I      = empty ? '0 : head[QW-1:XLEN];
  assign PCplus4_I   = empty ? '0 : head[XLEN-1:0];

endmodule

// File: tb/tb_if_stage_prefetch.sv
module tb_if_stage_prefetch;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall = 1'b0;
  logic        Branch_E = 1'b0, Jump_E = 1'b0, JReg = 1'b0;
  logic [31:0] BranchAddr = '0, Jaddr = '0, JRegAddr = '0;
  logic        MemReq;
  logic [11:0] MemAddr;
  logic        MemGnt = 1'b0;
  logic        MemValid = 1'b0;
  logic [31:0] MemData = '0;
  logic [31:0] Inst_I, PCplus4_I;
  logic        InstValid_I;

  if_stage_prefetch u_dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Stall       (Stall),
    .Branch_E    (Branch_E),
    .Jump_E      (Jump_E),
    .JReg        (JReg),
    .BranchAddr  (BranchAddr),
    .Jaddr       (Jaddr),
    .JRegAddr    (JRegAddr),
    .MemReq      (MemReq),
    .MemAddr     (MemAddr),
    .MemGnt      (MemGnt),
    .MemValid    (MemValid),
    .MemData     (MemData),
    .Inst_I      (Inst_I),
    .PCplus4_I   (PCplus4_I),
    .InstValid_I (InstValid_I)
  );

  always #5 Clk = ~Clk;

  // Staged controls, applied at the next falling edge.
  logic        n_reset = 1'b1, n_stall = 1'b0, n_br = 1'b0, n_j = 1'b0, n_jr = 1'b0;
  logic [31:0] n_baddr = '0, n_jaddr = '0, n_jraddr = '0;
  logic        gnt_off = 1'b0, inject = 1'b0, rnd = 1'b0;
  int          lat = 1;
  int          cyc_n = 0;
  int          last_due = 0;
  int          n_cmp = 0, n_err = 0;

  typedef struct {
    logic [11:0] addr;
    int          due;
  } req_t;
  req_t pending[$];

  function automatic logic [31:0] mdata(input logic [11:0] a);
    return {20'hD0000, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model: in-order responses, one per cycle, squashed on reset.
  task automatic mem_drive();
    MemValid = 1'b0;
    MemData  = '0;
    if (Reset) begin
      pending.delete();
      last_due = 0;
    end else if (inject) begin
      MemValid = 1'b1;
      MemData  = 32'hBAD0_0000;
    end else if (pending.size() > 0 && pending[0].due <= cyc_n) begin
      MemValid = 1'b1;
      MemData  = mdata(pending[0].addr);
      void'(pending.pop_front());
    end
    MemGnt = gnt_off ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
  endtask

  task automatic mem_capture();
    int l;
    int due;
    if (MemReq && MemGnt) begin
      l   = rnd ? int'($urandom_range(1, 5)) : lat;
      due = cyc_n + l;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pending.push_back('{addr: MemAddr, due: due});
    end
  endtask

  task automatic cyc();
    @(negedge Clk);
    Reset = n_reset; Stall = n_stall;
    Branch_E = n_br; Jump_E = n_j; JReg = n_jr;
    BranchAddr = n_baddr; Jaddr = n_jaddr; JRegAddr = n_jraddr;
    mem_drive();
    #1;
    mem_capture();
    cyc_n++;
  endtask

  task automatic do_reset();
    n_reset = 1'b1;
    cyc();
    n_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_pc4;
    int pops;

    // Reset values
    cyc();
    check("rst_memreq", MemReq, 0);
    check("rst_valid", InstValid_I, 0);
    check("rst_inst", Inst_I, 0);
    check("rst_pc4", PCplus4_I, 0);
    cyc();

    // Streaming, grant always, latency 1
    n_reset = 1'b0; lat = 1;
    cyc();  check("s_c0_req", MemReq, 1); check("s_c0_addr", MemAddr, 0);
    cyc();  check("s_c1_addr", MemAddr, 1); check("s_c1_valid", InstValid_I, 0);
    cyc();  check("s_c2_valid", InstValid_I, 1); check("s_c2_pc4", PCplus4_I, 4);
            check("s_c2_inst", Inst_I, 32'hD000_0000); check("s_c2_addr", MemAddr, 2);
    cyc();  check("s_c3_pc4", PCplus4_I, 8);
    cyc();  check("s_c4_pc4", PCplus4_I, 12); check("s_c4_inst", Inst_I, 32'hD000_0002);

    // Stall for 10 cycles: credits run out after DEPTH entries
    do_reset();
    n_stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (i == 4) check("stall_req_off", MemReq, 0);
    end
    check("stall_req_end", MemReq, 0);
    check("stall_valid", InstValid_I, 1);
    check("stall_inst", Inst_I, 32'hD000_0000);
    check("stall_pc4", PCplus4_I, 4);
    n_stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("release_valid", InstValid_I, 1);
      check("release_pc4", PCplus4_I, 32'(4 * (i + 1)));
    end

    // Branch with two requests in flight, latency 3
    do_reset();
    n_stall = 1'b1; lat = 3;
    for (int i = 0; i < 6; i++) cyc();
    n_br = 1'b1; n_baddr = 32'h100;
    cyc();  check("br_req", MemReq, 0); check("br_head_pc4", PCplus4_I, 4);
    n_br = 1'b0; n_stall = 1'b0;
    cyc();  check("br_flushed", InstValid_I, 0); check("br_c7_req", MemReq, 0);
    cyc();  check("br_c8_req", MemReq, 1); check("br_c8_addr", MemAddr, 12'h040);
    cyc();  check("br_c9_valid", InstValid_I, 0);
    cyc();  check("br_c10_valid", InstValid_I, 0);
    cyc();  check("br_c11_valid", InstValid_I, 0);
    cyc();  check("br_c12_valid", InstValid_I, 1); check("br_c12_pc4", PCplus4_I, 32'h104);
            check("br_c12_inst", Inst_I, 32'hD000_0040);

    // JReg and Jump_E together: JReg wins
    do_reset();
    lat = 1;
    n_jr = 1'b1; n_jraddr = 32'h200; n_j = 1'b1; n_jaddr = 32'h300;
    cyc();  check("jr_req", MemReq, 0);
    n_jr = 1'b0; n_j = 1'b0;
    cyc();  check("jr_c1_req", MemReq, 1); check("jr_c1_addr", MemAddr, 12'h080);
    cyc();
    cyc();  check("jr_c3_pc4", PCplus4_I, 32'h204); check("jr_c3_inst", Inst_I, 32'hD000_0080);
    // Jump_E over Branch_E, low target bits ignored, in-flight response discarded
    n_j = 1'b1; n_jaddr = 32'h303; n_br = 1'b1; n_baddr = 32'h500;
    cyc();  check("j_req", MemReq, 0);
    n_j = 1'b0; n_br = 1'b0;
    cyc();  check("j_addr", MemAddr, 12'h0C0);
    cyc();
    cyc();  check("j_pc4", PCplus4_I, 32'h304); check("j_inst", Inst_I, 32'hD000_00C0);

    // Random grant, latency and stall
    do_reset();
    rnd = 1'b1; exp_pc4 = 4; pops = 0;
    for (int i = 0; i < 1000; i++) begin
      n_stall = ($urandom_range(0, 3) == 0);
      cyc();
      check("occ_bound", {31'b0, (32'(u_dut.occ) <= 32'd4)}, 1);
      if (InstValid_I && !Stall) begin
        check("rnd_pc4", PCplus4_I, 32'(exp_pc4));
        check("rnd_inst", Inst_I, mdata(12'((exp_pc4 - 4) >> 2)));
        exp_pc4 += 4;
        pops++;
      end
    end
    check("rnd_progress", {31'b0, (pops > 100)}, 1);

    // Reset mid-stream, stray response ignored, then redirect to the wrap point
    rnd = 1'b0; n_stall = 1'b0;
    n_reset = 1'b1;
    cyc();  check("mid_rst_valid", InstValid_I, 0); check("mid_rst_req", MemReq, 0);
    n_reset = 1'b0; gnt_off = 1'b1; inject = 1'b1;
    cyc();  check("post_rst_req", MemReq, 1); check("post_rst_addr", MemAddr, 0);
    gnt_off = 1'b0; inject = 1'b0; lat = 1;
    n_j = 1'b1; n_jaddr = 32'hFFFF_FFFC;
    cyc();  check("stray_ignored", InstValid_I, 0); check("wrap_j_req", MemReq, 0);
    n_j = 1'b0;
    cyc();  check("wrap_addr_top", MemAddr, 12'hFFF);
    cyc();  check("wrap_addr_zero", MemAddr, 0);
    cyc();  check("wrap_pc4_0", PCplus4_I, 0); check("wrap_valid", InstValid_I, 1);
            check("wrap_inst", Inst_I, 32'hD000_0FFF);
    cyc();  check("wrap_pc4_4", PCplus4_I, 4); check("wrap_inst0", Inst_I, 32'hD000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_stage_prefetch.md
Name: if_stage_prefetch

Overview:
Parametrised successor to the single-cycle instruction fetch stage. Decouples PC generation from instruction memory latency. It issues fetch requests over a req/gnt/valid memory interface with variable latency and buffers returned instructions in a DEPTH-entry prefetch queue. The queue feeds the decode stage under Stall backpressure. Branch, jump and jump-register redirects from the execute stage flush the queue and discard stale in-flight responses.

Parameters:
XLEN, 32, instruction/PC width
IMEM_AW, 12, instruction memory word-address width
DEPTH, 4, prefetch queue entries (power of 2, >=2)
MAX_OUT, 2, max outstanding memory requests (>=1)
RESET_PC, 32'h0000_0000, PC after reset

Ports:
Clk  in  1  clock, all state on rising edge
Reset  in  1  asynchronous, active-high reset
Stall  in  1  decode cannot accept; hold head entry
Branch_E  in  1  taken branch redirect
Jump_E  in  1  J/JAL redirect
JReg  in  1  JR/JALR redirect
BranchAddr  in  XLEN  branch target
Jaddr  in  XLEN  jump target
JRegAddr  in  XLEN  register jump target
MemReq  out  1  fetch request valid
MemAddr  out  IMEM_AW  word address, equal to FetchPC[IMEM_AW+1:2]
MemGnt  in  1  memory accepts request this cycle
MemValid  in  1  response valid; responses return in order
MemData  in  XLEN  response instruction
Inst_I  out  XLEN  head instruction to decode
PCplus4_I  out  XLEN  head instruction PC+4
InstValid_I  out  1  head entry valid

Behaviour:
- Reset values:
  - FetchPC = RespPC = RESET_PC.
  - Queue empty; outstanding = 0; drop = 0.
  - MemReq = 0, InstValid_I = 0, Inst_I = 0, PCplus4_I = 0.
- Redirect is any of JReg, Jump_E, Branch_E. Priority when more than one is asserted: JReg > Jump_E > Branch_E. Target is the matching address input.
- Redirect cycle:
  - MemReq = 0.
  - Queue flushed at the clock edge.
  - FetchPC and RespPC both load the target.
  - drop loads (outstanding − MemValid).
  - Any MemValid in this cycle is discarded.
  - First request to the target is issued in the next cycle.
- Issue rule: MemReq = !Reset && !redirect && (outstanding < MAX_OUT) && (occupancy + outstanding < DEPTH). This credit rule guarantees the queue never overflows.
- Request acceptance: when MemReq && MemGnt, FetchPC += 4 and outstanding += 1.
- Response:
  - Every MemValid decrements outstanding.
  - If drop > 0: drop −= 1, data discarded.
  - Else: push {MemData, RespPC+4}, then RespPC += 4.
- Outstanding update: a grant and a response in the same cycle leave outstanding unchanged.
- Output: Inst_I, PCplus4_I and InstValid_I reflect the queue head; InstValid_I = !empty.
  - Pop when InstValid_I && !Stall && !redirect.
  - Pushing into an empty queue makes the entry visible on the next cycle (1-cycle min latency from MemValid).
  - Push and pop in the same cycle keep occupancy unchanged.
- Stall: head and the remaining queue contents held; fetching continues until credits are exhausted.
- PC arithmetic is modulo 2^XLEN; wrap at 32'hFFFF_FFFC is legal. Target bits [1:0] are ignored (forced 0).
- Reset mid-operation clears all state at once; late responses after reset are not counted (outstanding = 0) and must be ignored. Memory is required to squash its own in-flight responses on Reset.

Decomposition:
- Package if_pkg: XLEN default, redirect-priority encoding constants, RESET_PC default.
- Sub-module: if_prefetch_fifo (DEPTH x 2*XLEN, push/pop/flush, count output, registered head).
- Top level holds the PC/RespPC registers, the outstanding/drop counters and the redirect mux.

Test Plan:
- Reset, then MemGnt = 1 and fixed 1-cycle latency, Stall = 0 → MemReq first at cycle 1 with MemAddr 0, 1, 2…; PCplus4_I = 4, 8, 12…; one instruction per cycle in steady state.
- Stall = 1 for 10 cycles → MemReq drops after DEPTH entries are buffered; Inst_I holds PC 0 data; after release 4 back-to-back entries with no bubble.
- Branch_E = 1, BranchAddr = 0x100, with 2 requests outstanding → queue empties next cycle; 2 responses dropped; next InstValid_I shows PCplus4_I = 0x104.
- JReg = 1 (0x200) and Jump_E = 1 (0x300) asserted together → first MemAddr = 0x80 (0x200>>2).
- Random MemGnt/latency 1–5 over 1000 cycles → in-order PCplus4_I sequence matches a reference model; occupancy never exceeds DEPTH.
- Reset asserted mid-stream, Jaddr = 0xFFFF_FFFC redirect then run → PC wraps to 0; post-reset fetch restarts at RESET_PC.
